// File: rtl/NVM_pkg.sv
// Shared geometry, address types and GC responder state encoding for the remapping table.
// Pure declarations; no timing or flow-control behaviour of its own.
package NVM_pkg;

  localparam int NUM_BLK       = 16;
  localparam int PAGES_PER_BLK = 8;
  localparam int BLK_W         = $clog2(NUM_BLK);
  localparam int PG_W          = $clog2(PAGES_PER_BLK);
  localparam int CNT_W         = PG_W + 1;

  typedef logic [BLK_W-1:0]         block_t;
  typedef logic [PG_W-1:0]          page_t;
  typedef logic [CNT_W-1:0]         cnt_t;
  typedef logic [PAGES_PER_BLK-1:0] pg_mask_t;

  localparam cnt_t  CNT_MAX = cnt_t'(PAGES_PER_BLK);
  localparam page_t LAST_PG = page_t'(PAGES_PER_BLK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    COPY = 2'd2,
    DONE = 2'd3
  } gc_resp_state_t;

  // Invalid counts stick at a full block rather than wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c >= CNT_MAX) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/victim_select.sv
// Combinational max-index tree over per-block invalid counts; excluded block never wins, ties go low.
// Zero latency, no flow control.
module victim_select
  import NVM_pkg::*;
(
  input  cnt_t   cnt [NUM_BLK],
  input  block_t excl,
  output block_t win_idx,
  output cnt_t   win_cnt
);

  // Heap layout: node n combines children 2n (lower indices) and 2n+1; leaves at NUM_BLK+b.
  logic   nv [1:2*NUM_BLK-1];
  block_t ni [1:2*NUM_BLK-1];
  cnt_t   nc [1:2*NUM_BLK-1];
  logic   take_left;

  always_comb begin
    take_left = 1'b0;
    for (int n = 1; n < 2*NUM_BLK; n++) begin
      nv[n] = 1'b0;
      ni[n] = '0;
      nc[n] = '0;
    end
    for (int b = 0; b < NUM_BLK; b++) begin
      nv[NUM_BLK+b] = (block_t'(b) != excl);
      ni[NUM_BLK+b] = block_t'(b);
      nc[NUM_BLK+b] = cnt[b];
    end
    for (int n = NUM_BLK - 1; n >= 1; n--) begin
      take_left = nv[2*n] && (!nv[2*n+1] || (nc[2*n] >= nc[2*n+1]));
      nv[n] = nv[2*n] | nv[2*n+1];
      ni[n] = take_left ? ni[2*n] : ni[2*n+1];
      nc[n] = take_left ? nc[2*n] : nc[2*n+1];
    end
  end

  assign win_idx = ni[1];
  assign win_cnt = nc[1];

endmodule

// File: rtl/remap_gc_responder.sv
// Remap-table side of GC: page valid/invalid-count tracking, victim nomination, valid-page relocation.
// Victim outputs 1 cycle behind counts; each copy holds copy_req/addresses until copy_ack.
module remap_gc_responder
  import NVM_pkg::*;
#(
  parameter int GC_THRESH = 6
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   prog_en,
  input  block_t prog_blk,
  input  page_t  prog_pg,
  input  logic   inv_en,
  input  block_t inv_blk,
  input  page_t  inv_pg,
  input  block_t erase_blk,
  input  block_t active_blk,
  input  logic   move_flag,
  output block_t invalid_blk,
  output logic   invalid_flag,
  output logic   move_done_flag,
  output logic   copy_req,
  output block_t copy_src_blk,
  output page_t  copy_src_pg,
  output block_t copy_dst_blk,
  output page_t  copy_dst_pg,
  input  logic   copy_ack
);

  localparam cnt_t THRESH = cnt_t'(GC_THRESH);

  gc_resp_state_t state, state_nxt;
  block_t         src, src_nxt, dst, dst_nxt;
  page_t          sp, sp_nxt, dp, dp_nxt;
  logic           pend_inv, pend_nxt;
  pg_mask_t       valid     [NUM_BLK];
  pg_mask_t       valid_nxt [NUM_BLK];
  cnt_t           inv_cnt   [NUM_BLK];
  cnt_t           cnt_nxt   [NUM_BLK];
  block_t         vs_idx;
  cnt_t           vs_cnt;
  logic           src_inv_hit, taint, copy_fire;

  victim_select u_victim_select (
    .cnt     (inv_cnt),
    .excl    (active_blk),
    .win_idx (vs_idx),
    .win_cnt (vs_cnt)
  );

  // A host invalidate of the page being copied makes the destination copy stale on arrival.
  assign src_inv_hit = inv_en && (inv_blk == src) && (inv_pg == sp);
  assign taint       = pend_inv | src_inv_hit;
  assign copy_fire   = (state == COPY) && copy_ack;

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    dst_nxt   = dst;
    sp_nxt    = sp;
    dp_nxt    = dp;
    pend_nxt  = pend_inv;
    case (state)
      IDLE: begin
        if (move_flag) begin
          state_nxt = SCAN;
          src_nxt   = erase_blk;
          dst_nxt   = active_blk;
          sp_nxt    = '0;
          dp_nxt    = '0;
          pend_nxt  = 1'b0;
        end
      end
      SCAN: begin
        if (valid[src][sp]) begin
          state_nxt = COPY;
          pend_nxt  = src_inv_hit;
        end else if (sp == LAST_PG) begin
          state_nxt = DONE;
        end else begin
          sp_nxt = sp + page_t'(1);
        end
      end
      COPY: begin
        if (copy_ack) begin
          dp_nxt   = dp + page_t'(1);
          pend_nxt = 1'b0;
          if (sp == LAST_PG) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            sp_nxt    = sp + page_t'(1);
          end
        end else begin
          pend_nxt = taint;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Host invalidate, then host program, then relocation effects, then block erase.
  always_comb begin
    valid_nxt = valid;
    cnt_nxt   = inv_cnt;
    if (inv_en) begin
      if (valid[inv_blk][inv_pg]) cnt_nxt[inv_blk] = sat_inc(inv_cnt[inv_blk]);
      valid_nxt[inv_blk][inv_pg] = 1'b0;
    end
    if (prog_en) valid_nxt[prog_blk][prog_pg] = 1'b1;
    if (copy_fire) begin
      valid_nxt[src][sp] = 1'b0;
      valid_nxt[dst][dp] = ~taint;
      if (taint) cnt_nxt[dst] = sat_inc(cnt_nxt[dst]);
    end
    if (state == DONE) begin
      valid_nxt[src] = '0;
      cnt_nxt[src]   = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      sp           <= '0;
      dp           <= '0;
      pend_inv     <= 1'b0;
      valid        <= '{default: '0};
      inv_cnt      <= '{default: '0};
      invalid_blk  <= '0;
      invalid_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      src      <= src_nxt;
      dst      <= dst_nxt;
      sp       <= sp_nxt;
      dp       <= dp_nxt;
      pend_inv <= pend_nxt;
      valid    <= valid_nxt;
      inv_cnt  <= cnt_nxt;
      if (state == IDLE) begin
        invalid_blk  <= vs_idx;
        invalid_flag <= (vs_cnt >= THRESH);
      end
    end
  end

  assign copy_req       = (state == COPY);
  assign move_done_flag = (state == DONE);
  assign copy_src_blk   = src;
  assign copy_src_pg    = sp;
  assign copy_dst_blk   = dst;
  assign copy_dst_pg    = dp;

endmodule

// File: tb/tb_remap_gc_responder.sv
// Directed and random checks of remap_gc_responder against a page/count reference model.
module tb_remap_gc_responder;
  import NVM_pkg::*;

  localparam int P  = PAGES_PER_BLK;
  localparam int NB = NUM_BLK;
  localparam int TH = 6;

  logic   CLK = 1'b0;
  logic   nRST = 1'b0;
  logic   prog_en = 1'b0, inv_en = 1'b0, move_flag = 1'b0, copy_ack = 1'b0;
  block_t prog_blk = '0, inv_blk = '0, erase_blk = '0, active_blk = '0;
  page_t  prog_pg = '0, inv_pg = '0;
  block_t invalid_blk, copy_src_blk, copy_dst_blk;
  page_t  copy_src_pg, copy_dst_pg;
  logic   invalid_flag, move_done_flag, copy_req;

  always #5 CLK = ~CLK;

  remap_gc_responder #(.GC_THRESH(TH)) dut (
    .CLK(CLK), .nRST(nRST),
    .prog_en(prog_en), .prog_blk(prog_blk), .prog_pg(prog_pg),
    .inv_en(inv_en), .inv_blk(inv_blk), .inv_pg(inv_pg),
    .erase_blk(erase_blk), .active_blk(active_blk), .move_flag(move_flag),
    .invalid_blk(invalid_blk), .invalid_flag(invalid_flag), .move_done_flag(move_done_flag),
    .copy_req(copy_req), .copy_src_blk(copy_src_blk), .copy_src_pg(copy_src_pg),
    .copy_dst_blk(copy_dst_blk), .copy_dst_pg(copy_dst_pg), .copy_ack(copy_ack)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: what the table should hold, in plain arrays.
  bit [P-1:0] mvalid [NB];
  int         mcnt   [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic m_clear();
    for (int b = 0; b < NB; b++) begin
      mvalid[b] = '0;
      mcnt[b]   = 0;
    end
  endtask

  task automatic m_host(input bit ie, input int ib, input int ip,
                        input bit pe, input int pb, input int pp);
    if (ie) begin
      if (mvalid[ib][ip]) mcnt[ib] = (mcnt[ib] < P) ? mcnt[ib] + 1 : P;
      mvalid[ib][ip] = 1'b0;
    end
    if (pe) mvalid[pb][pp] = 1'b1;
  endtask

  function automatic int vict(input int act);
    int best = -1;
    for (int b = 0; b < NB; b++)
      if (b != act && (best < 0 || mcnt[b] > mcnt[best])) best = b;
    return best;
  endfunction

  task automatic host(input bit ie, input int ib, input int ip,
                      input bit pe, input int pb, input int pp);
    inv_en = ie;  inv_blk = block_t'(ib);  inv_pg = page_t'(ip);
    prog_en = pe; prog_blk = block_t'(pb); prog_pg = page_t'(pp);
    step();
    inv_en = 1'b0;
    prog_en = 1'b0;
    m_host(ie, ib, ip, pe, pb, pp);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    inv_en = 1'b0; prog_en = 1'b0; move_flag = 1'b0; copy_ack = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();
    m_clear();
  endtask

  task automatic setup_blk(input int b, input int np, input int ni);
    for (int p = 0; p < np; p++) host(1'b0, 0, 0, 1'b1, b, p);
    for (int p = 0; p < ni; p++) host(1'b1, b, p, 1'b0, 0, 0);
  endtask

  task automatic check_victim(input string tag, input int act);
    int v = vict(act);
    chk({tag, "_blk"}, 32'(invalid_blk), 32'(v));
    chk({tag, "_flag"}, 32'(invalid_flag), 32'(mcnt[v] >= TH));
  endtask

  task automatic check_blk(input string tag, input int b);
    chk({tag, "_valid"}, 32'(dut.valid[b]), 32'(mvalid[b]));
    chk({tag, "_cnt"}, 32'(dut.inv_cnt[b]), 32'(mcnt[b]));
  endtask

  // Runs one move with a fixed ack delay, optionally invalidating a source page mid-copy
  // and optionally re-pulsing move_flag while busy.
  task automatic run_move(input int e, input int a, input int dly, input int hit_pg, input bit poke);
    int     exp_pg[$];
    bit     tq [P];
    int     idx = 0, reqc = 0, n = 1, done_n = -1, exp_done;
    bit     injected = 1'b0;
    for (int p = 0; p < P; p++) begin
      tq[p] = 1'b0;
      if (mvalid[e][p]) exp_pg.push_back(p);
    end
    exp_done = P + 1 + exp_pg.size() * (1 + dly);
    erase_blk = block_t'(e); active_blk = block_t'(a); move_flag = 1'b1;
    step();
    move_flag = 1'b0;
    while (n < 300) begin
      if (move_done_flag) begin
        done_n = n;
        break;
      end
      if (poke && n == 3) begin
        move_flag = 1'b1;
        erase_blk = block_t'(5);
      end
      if (copy_req) begin
        if (idx < exp_pg.size()) begin
          chk("copy_src_blk", 32'(copy_src_blk), 32'(e));
          chk("copy_src_pg", 32'(copy_src_pg), 32'(exp_pg[idx]));
          chk("copy_dst_blk", 32'(copy_dst_blk), 32'(a));
          chk("copy_dst_pg", 32'(copy_dst_pg), 32'(idx));
          if (hit_pg == exp_pg[idx] && !injected) begin
            inv_en = 1'b1; inv_blk = block_t'(e); inv_pg = page_t'(hit_pg);
            injected = 1'b1;
            tq[idx] = 1'b1;
            m_host(1'b1, e, hit_pg, 1'b0, 0, 0);
          end
        end else begin
          chk("copy_overrun", 32'(idx), 32'(exp_pg.size() - 1));
        end
        reqc++;
        if (reqc == dly + 1) begin
          copy_ack = 1'b1;
          idx++;
          reqc = 0;
        end
      end
      step();
      copy_ack = 1'b0;
      inv_en = 1'b0;
      move_flag = 1'b0;
      n++;
    end
    chk("move_done_cycle", 32'(done_n), 32'(exp_done));
    chk("copies_made", 32'(idx), 32'(exp_pg.size()));
    for (int i = 0; i < exp_pg.size(); i++) begin
      mvalid[a][i] = !tq[i];
      if (tq[i]) mcnt[a] = (mcnt[a] < P) ? mcnt[a] + 1 : P;
    end
    mvalid[e] = '0;
    mcnt[e]   = 0;
    step();
    chk("done_pulse_width", 32'(move_done_flag), 32'(0));
    step();
    check_victim("post_move", a);
    check_blk("post_move_src", e);
    check_blk("post_move_dst", a);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act, exp_b, exp_f, w, dcount;
    bit ie, pe;
    int ib, ip, pb, pp;

    // Reset state
    #3;
    chk("rst_invalid_blk", 32'(invalid_blk), 32'(0));
    chk("rst_invalid_flag", 32'(invalid_flag), 32'(0));
    chk("rst_move_done", 32'(move_done_flag), 32'(0));
    chk("rst_copy_req", 32'(copy_req), 32'(0));
    chk("rst_copy_addr", 32'({copy_src_blk, copy_src_pg, copy_dst_blk, copy_dst_pg}), 32'(0));
    do_reset();

    // Victim reaches threshold; repeat invalidate is a no-op; same-cycle inv+prog
    active_blk = block_t'(9);
    setup_blk(3, 8, 6);
    step();
    check_victim("a_thresh", 9);
    host(1'b1, 3, 0, 1'b0, 0, 0);
    check_blk("a_reinv", 3);
    host(1'b1, 3, 6, 1'b1, 3, 6);
    check_blk("a_inv_prog", 3);
    step();
    check_victim("a_after", 9);

    // Tie-break to lowest index, then exclusion of the active block
    do_reset();
    active_blk = block_t'(9);
    setup_blk(2, 4, 4);
    setup_blk(5, 4, 4);
    setup_blk(7, 3, 3);
    step();
    check_victim("b_tie", 9);
    active_blk = block_t'(2);
    step();
    step();
    check_victim("b_excl", 2);

    // Move with immediate ack
    do_reset();
    active_blk = block_t'(9);
    setup_blk(3, 8, 6);
    step();
    run_move(3, 9, 0, -1, 1'b0);

    // Move with 3-cycle ack delay and an ignored second move_flag
    do_reset();
    active_blk = block_t'(9);
    setup_blk(3, 8, 6);
    step();
    run_move(3, 9, 3, -1, 1'b1);

    // Invalidate of the page being copied
    do_reset();
    active_blk = block_t'(9);
    setup_blk(3, 8, 6);
    step();
    run_move(3, 9, 3, 6, 1'b0);

    // Reset during COPY aborts the move
    do_reset();
    active_blk = block_t'(9);
    setup_blk(3, 8, 6);
    step();
    erase_blk = block_t'(3); move_flag = 1'b1;
    step();
    move_flag = 1'b0;
    w = 0;
    while (!copy_req && w < 20) begin
      step();
      w++;
    end
    chk("f_reached_copy", 32'(copy_req), 32'(1));
    #2 nRST = 1'b0;
    #1;
    chk("f_copy_req_async", 32'(copy_req), 32'(0));
    chk("f_addr_zero", 32'({copy_src_blk, copy_src_pg, copy_dst_blk, copy_dst_pg}), 32'(0));
    chk("f_victim_zero", 32'({invalid_blk, invalid_flag}), 32'(0));
    chk("f_done_zero", 32'(move_done_flag), 32'(0));
    step();
    nRST = 1'b1;
    step();
    chk("f_state_idle", 32'(dut.state), 32'(IDLE));
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (move_done_flag) dcount++;
      step();
    end
    chk("f_no_done", 32'(dcount), 32'(0));
    m_clear();

    // Random host traffic with per-cycle victim checks, each round ending in a move
    do_reset();
    for (int round = 0; round < 3; round++) begin
      act = $urandom_range(8, 15);
      active_blk = block_t'(act);
      step();
      exp_b = vict(act);
      exp_f = (mcnt[exp_b] >= TH) ? 1 : 0;
      for (int i = 0; i < 250; i++) begin
        ie = ($urandom_range(0, 2) != 0);
        pe = ($urandom_range(0, 1) != 0);
        ib = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : $urandom_range(0, 3);
        pb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : $urandom_range(0, 3);
        ip = $urandom_range(0, P - 1);
        pp = ($urandom_range(0, 7) == 0) ? ip : $urandom_range(0, P - 1);
        if ($urandom_range(0, 7) == 0) pb = ib;
        inv_en = ie;  inv_blk = block_t'(ib);  inv_pg = page_t'(ip);
        prog_en = pe; prog_blk = block_t'(pb); prog_pg = page_t'(pp);
        step();
        inv_en = 1'b0;
        prog_en = 1'b0;
        chk("r_victim_blk", 32'(invalid_blk), 32'(exp_b));
        chk("r_victim_flag", 32'(invalid_flag), 32'(exp_f));
        m_host(ie, ib, ip, pe, pb, pp);
        exp_b = vict(act);
        exp_f = (mcnt[exp_b] >= TH) ? 1 : 0;
      end
      step();
      for (int b = 0; b < NB; b++) check_blk("r_table", b);
      run_move(vict(act), act, $urandom_range(0, 2), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/remap_gc_responder.md
# remap_gc_responder

Remapping-table side of the garbage-collection handshake. Tracks per-page valid bits and per-block invalid-page counts, and nominates the victim block to the GC controller through `invalid_blk` / `invalid_flag`. On `move_flag` it relocates every still-valid page of `erase_blk` into `active_blk` through a copy handshake to the NVM array, then answers with `move_done_flag`.

## Interface
Parameters:
- `NUM_BLK`, 16: number of blocks; power of two.
- `PAGES_PER_BLK`, 8: pages per block; power of two.
- `GC_THRESH`, 6: minimum invalid count that raises `invalid_flag`; range 1..PAGES_PER_BLK.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `prog_en` in 1: host programmed a page.
- `prog_blk` in block_t, `prog_pg` in page_t: programmed location.
- `inv_en` in 1: host invalidated a page (overwrite or trim).
- `inv_blk` in block_t, `inv_pg` in page_t: invalidated location.
- `erase_blk` in block_t: GC source block, sampled with `move_flag`.
- `active_blk` in block_t: GC destination block, sampled with `move_flag`; excluded from victim search.
- `move_flag` in 1: one-cycle start-of-move pulse.
- `invalid_blk` out block_t: nominated victim.
- `invalid_flag` out 1: the victim's count is ≥ GC_THRESH.
- `move_done_flag` out 1: one-cycle pulse when the move completes.
- `copy_req` out 1: page-copy request to the array.
- `copy_src_blk`, `copy_dst_blk` out block_t; `copy_src_pg`, `copy_dst_pg` out page_t: copy addresses.
- `copy_ack` in 1: array accepted the copy.

## Operation
- State: `valid[NUM_BLK][PAGES_PER_BLK]` and `inv_cnt[NUM_BLK]`, each `$clog2(PAGES_PER_BLK)+1` bits, saturating at PAGES_PER_BLK.
- Program updates: `prog_en` sets the valid bit.
- Invalidate updates: `inv_en` clears the valid bit. It increments `inv_cnt` only if the bit was set; otherwise it is a no-op.
- Program and invalidate on the same page in the same cycle: apply the invalidate first, then the program. The page ends valid, and the count increments only if the page was previously valid.
- Victim search (IDLE only):
  - Pick the block with the maximum `inv_cnt`, excluding `active_blk`; ties go to the lowest index.
  - Register the result into `invalid_blk` and set `invalid_flag` = (count ≥ GC_THRESH).
  - Outside IDLE, both outputs hold their last value.
- FSM states are IDLE, SCAN, COPY and DONE.
- IDLE → SCAN on `move_flag`. On entry:
  - latch `src` = `erase_blk` and `dst` = `active_blk`;
  - clear the scan pointer `sp` and the destination pointer `dp`.
  - `move_flag` in any other state is ignored.
- SCAN (one page per cycle):
  - If `valid[src][sp]`, go to COPY.
  - Otherwise increment `sp`.
  - Leaving `sp` = PAGES_PER_BLK−1 goes to DONE.
- COPY:
  - Drive `copy_req`=1 with src/sp and dst/dp, held stable until `copy_ack`.
  - `copy_ack` may arrive in the same cycle as the request.
  - On ack: set `valid[dst][dp]`, clear `valid[src][sp]`, increment `dp`, then advance `sp` (to DONE if it was the last page, else SCAN).
- Invalidate of `src`/`sp` while in COPY:
  - The copy still completes.
  - On ack, `valid[dst][dp]` is written 0, and `inv_cnt[dst]` increments.
- DONE:
  - Clear all of `valid[src]` and set `inv_cnt[src]`=0.
  - Pulse `move_done_flag` for one cycle, then return to IDLE.
- Host program/invalidate are accepted in every state. The controller guarantees no `prog_en` to `src` or `dst` during a move.

## Timing
- Reset value of every output is 0. All state and the FSM clear to 0 / IDLE.
- Reset mid-move aborts the move: `copy_req` drops asynchronously with `nRST`, and no `move_done_flag` is produced.
- Victim outputs have 1-cycle latency from the count change to `invalid_blk`/`invalid_flag`.
- Move latency, with `move_flag` at cycle 0 and P = PAGES_PER_BLK:
  - Zero valid pages: SCAN occupies cycles 1..P, and `move_done_flag` is high at cycle P+1.
  - Each valid page adds 1 + (ack wait) cycles.
  - Example: P=8, all 8 pages valid, immediate ack → `move_done_flag` at cycle 17.
- `copy_*` address outputs are registered and valid whenever `copy_req`=1.

## Structure
- NVM_pkg holds `block_t`, `page_t`, `NUM_BLK`, `PAGES_PER_BLK`, and the FSM enum `gc_resp_state_t`.
- Victim selection is one sub-module, `victim_select`: a combinational max-index tree over `inv_cnt` with an exclude input and lowest-index tie-break.

## Test plan
- Program blk 3 pages 0..7, then invalidate pages 0..5 → after the 6th invalidate, the next cycle shows `invalid_blk`=3 and `invalid_flag`=1. Invalidating an already-invalid page leaves the count at 6.
- Counts blk2=4, blk5=4, blk7=3 with GC_THRESH=6 → `invalid_blk`=2 and `invalid_flag`=0. Setting `active_blk`=2 → `invalid_blk`=5.
- Move with `erase_blk`=3 (pages 6,7 valid), `active_blk`=9, immediate ack → copies (3,6)→(9,0) and (3,7)→(9,1). `move_done_flag` at cycle 11, `inv_cnt[3]`=0, `valid[9]`=0b00000011.
- Same move with `copy_ack` delayed 3 cycles → `copy_req` and addresses stay stable for 4 cycles per page. A second `move_flag` while busy is ignored.
- Invalidate (3,6) while its COPY is pending → after ack, `valid[9][0]`=0 and `inv_cnt[9]`=1.
- Assert `nRST` low during COPY → `copy_req` drops immediately, all outputs read 0, and the FSM is in IDLE after release.
